// File: rtl/coproc_pkg.sv
// Shared types for the gray-to-RGB streaming coprocessor: pixel formats,
// conversion mode, FSM encoding and palette geometry.
package coproc_pkg;

  typedef logic [3:0]  gray4_t;
  typedef logic [11:0] rgb444_t;

  typedef enum logic {
    MODE_REPL = 1'b0,
    MODE_PAL  = 1'b1
  } pix_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } fsm_state_e;

  localparam int PAL_DEPTH = 16;
  localparam int PAL_AW    = $clog2(PAL_DEPTH);

  // Gray level copied into all three channels; also the palette reset ramp.
  function automatic rgb444_t gray_replicate(input gray4_t g);
    return {g, g, g};
  endfunction

endpackage

// File: rtl/gray_palette_rf.sv
// 16-entry x 12-bit palette: one synchronous write port, one asynchronous
// read port, asynchronously reset to the identity gray ramp.
module gray_palette_rf
  import coproc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [PAL_AW-1:0] waddr_i,
  input  rgb444_t           wdata_i,
  input  logic [PAL_AW-1:0] raddr_i,
  output rgb444_t           rdata_o
);

  rgb444_t mem_q [PAL_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        mem_q[i] <= gray_replicate(gray4_t'(i));
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see the registered contents, so a same-cycle write is not visible.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/gray2rgb_stream.sv
// Streaming 4-bit gray to RGB444 converter with a single output register
// stage, per-frame mode latching, a writable palette and frame accounting.
module gray2rgb_stream
  import coproc_pkg::*;
#(
  parameter int PIX_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic                 pal_we,
  input  logic [3:0]           pal_addr,
  input  logic [11:0]          pal_wdata,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_gray,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [11:0]          out_rgb,
  output logic                 out_last,
  output logic                 frame_done,
  output logic [PIX_CNT_W-1:0] pix_cnt,
  output fsm_state_e           dbg_state
);

  localparam logic [PIX_CNT_W-1:0] CNT_ONE = {{(PIX_CNT_W-1){1'b0}}, 1'b1};

  // Handshakes: a beat transfers on a rising edge where valid && ready.
  // The output register can accept a new pixel when it is empty or is being
  // drained in the same cycle; valid never drops and data never changes
  // while a beat is stalled.
  logic in_hs;
  logic out_hs;

  fsm_state_e           state_q,      state_d;
  pix_mode_e            mode_q,       mode_d;
  logic                 out_valid_q,  out_valid_d;
  rgb444_t              out_rgb_q,    out_rgb_d;
  logic                 out_last_q,   out_last_d;
  logic [PIX_CNT_W-1:0] pix_cnt_q,    pix_cnt_d;
  logic                 frame_done_q, frame_done_d;

  pix_mode_e eff_mode;
  rgb444_t   pal_rdata;
  rgb444_t   pix_rgb;

  assign in_ready = !out_valid_q || out_ready;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  gray_palette_rf u_palette (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (pal_we),
    .waddr_i (pal_addr),
    .wdata_i (pal_wdata),
    .raddr_i (in_gray),
    .rdata_o (pal_rdata)
  );

  // The first pixel of a frame uses the live mode; later ones the latched one.
  always_comb begin
    eff_mode = (state_q == ST_IDLE) ? pix_mode_e'(mode) : mode_q;
    pix_rgb  = (eff_mode == MODE_PAL) ? pal_rdata : gray_replicate(in_gray);
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    out_valid_d  = out_valid_q;
    out_rgb_d    = out_rgb_q;
    out_last_d   = out_last_q;
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = out_hs && out_last_q;

    if (out_hs) begin
      out_valid_d = 1'b0;
      pix_cnt_d   = out_last_q ? '0 : pix_cnt_q + CNT_ONE;
    end

    if (in_hs) begin
      out_valid_d = 1'b1;
      out_rgb_d   = pix_rgb;
      out_last_d  = in_last;
      case (state_q)
        ST_IDLE: begin
          mode_d  = pix_mode_e'(mode);
          state_d = in_last ? ST_IDLE : ST_ACTIVE;
        end
        ST_ACTIVE: begin
          state_d = in_last ? ST_IDLE : ST_ACTIVE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_REPL;
      out_valid_q  <= 1'b0;
      out_rgb_q    <= '0;
      out_last_q   <= 1'b0;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      out_valid_q  <= out_valid_d;
      out_rgb_q    <= out_rgb_d;
      out_last_q   <= out_last_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_rgb    = out_rgb_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign pix_cnt    = pix_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_gray2rgb_stream.sv
// Bench for gray2rgb_stream: per-scenario tasks, a reference model that
// queues expected {last,rgb} beats on acceptance, and a negedge monitor.
module tb_gray2rgb_stream;
  import coproc_pkg::*;

  localparam int W = 13;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_addr = '0;
  logic [11:0] pal_wdata = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_gray = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_rgb;
  logic        out_last;
  logic        frame_done;
  logic [15:0] pix_cnt;
  fsm_state_e  dbg_state;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [11:0]  pal_m [16];
  logic         st_m;
  logic         mode_m;
  logic [15:0]  cnt_m;
  logic         fd_m;
  int           fd_count;
  logic         rand_ready = 1'b0;

  always #5 clk = ~clk;

  gray2rgb_stream #(.PIX_CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .pal_we     (pal_we),
    .pal_addr   (pal_addr),
    .pal_wdata  (pal_wdata),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_gray    (in_gray),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rgb    (out_rgb),
    .out_last   (out_last),
    .frame_done (frame_done),
    .pix_cnt    (pix_cnt),
    .dbg_state  (dbg_state)
  );

  // Monitor: pops the scoreboard on each output handshake and tracks the
  // expected pixel counter and frame_done pulse.
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic         fd_next;
    if (rst_n) begin
      checks++;
      if (pix_cnt !== cnt_m) begin
        failures++;
        $display("FAIL pix_cnt: got %0d exp %0d at %0t", pix_cnt, cnt_m, $time);
      end
      checks++;
      if (frame_done !== fd_m) begin
        failures++;
        $display("FAIL frame_done: got %b exp %b at %0t", frame_done, fd_m, $time);
      end
      if (frame_done === 1'b1) fd_count++;
      fd_next = 1'b0;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_extra: got rgb %h with no pixel expected at %0t", out_rgb, $time);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_rgb} !== e) begin
            failures++;
            $display("FAIL sb_pixel: got last=%b rgb=%h exp last=%b rgb=%h at %0t",
                     out_last, out_rgb, e[12], e[11:0], $time);
          end
        end
        if (out_last === 1'b1) begin
          cnt_m   = '0;
          fd_next = 1'b1;
        end else begin
          cnt_m = cnt_m + 16'd1;
        end
      end
      fd_m = fd_next;
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) pal_m[i] = {i[3:0], i[3:0], i[3:0]};
    st_m   = 1'b0;
    mode_m = 1'b0;
    cnt_m  = '0;
    fd_m   = 1'b0;
    exp_q.delete();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    pal_we   = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Drives one pixel (optionally with a palette write) until accepted.
  // Call at posedge+#1; returns at posedge+#1 right after the accepting edge.
  task automatic drive(input logic [3:0] g, input logic last, input logic m,
                       input logic we, input logic [3:0] wa, input logic [11:0] wd);
    logic        accepted;
    logic        eff;
    logic [11:0] e;
    accepted  = 1'b0;
    in_valid  = 1'b1;
    in_gray   = g;
    in_last   = last;
    mode      = m;
    pal_we    = we;
    pal_addr  = wa;
    pal_wdata = wd;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        eff = st_m ? mode_m : m;
        e   = eff ? pal_m[g] : {g, g, g};
        exp_q.push_back({last, e});
        if (!st_m) mode_m = m;
        st_m     = !last;
        accepted = 1'b1;
      end
      if (pal_we) pal_m[wa] = wd;
      @(posedge clk); #1;
      if (accepted) break;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    pal_we   = 1'b0;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    checks++;
    if (!accepted) begin
      failures++;
      $display("FAIL accept_timeout: gray %h not accepted within 64 cycles", g);
    end
  endtask

  task automatic pal_write(input logic [3:0] a, input logic [11:0] d);
    pal_we    = 1'b1;
    pal_addr  = a;
    pal_wdata = d;
    @(negedge clk);
    pal_m[a] = d;
    @(posedge clk); #1;
    pal_we = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d pixels still expected, exp 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_rgb !== 12'h000 || out_last !== 1'b0 ||
        frame_done !== 1'b0 || pix_cnt !== 16'd0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state: rdy=%b vld=%b rgb=%h last=%b fd=%b cnt=%0d st=%0d exp 1,0,000,0,0,0,0",
               in_ready, out_valid, out_rgb, out_last, frame_done, pix_cnt, dbg_state);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after: got %b exp 1", in_ready);
    end
  endtask

  task automatic test_replicate();
    for (int g = 0; g < 16; g++) begin
      drive(4'(g), g == 15, 1'b0, 1'b0, 4'h0, 12'h000);
      checks++;
      if (out_valid !== 1'b1 || out_rgb !== {3{4'(g)}}) begin
        failures++;
        $display("FAIL repl_latency: vld=%b rgb=%h exp 1,%h", out_valid, out_rgb, {3{4'(g)}});
      end
    end
    drain("repl");
  endtask

  task automatic test_palette();
    pal_write(4'd5, 12'hA3C);
    drive(4'd5, 1'b0, 1'b1, 1'b0, 4'h0, 12'h000);
    checks++;
    if (out_rgb !== 12'hA3C) begin
      failures++;
      $display("FAIL pal_entry5: got %h exp a3c", out_rgb);
    end
    drive(4'd6, 1'b1, 1'b1, 1'b0, 4'h0, 12'h000);
    checks++;
    if (out_rgb !== 12'h666) begin
      failures++;
      $display("FAIL pal_entry6: got %h exp 666", out_rgb);
    end
    drain("pal");
  endtask

  task automatic test_stall();
    drive(4'd1, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000);
    drive(4'd2, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_gray   = 4'd3;
    in_last   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_rgb !== 12'h222) begin
        failures++;
        $display("FAIL stall_hold: rdy=%b vld=%b rgb=%h exp 0,1,222", in_ready, out_valid, out_rgb);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drive(4'd3, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000);
    drive(4'd4, 1'b1, 1'b0, 1'b0, 4'h0, 12'h000);
    drain("stall");
  endtask

  task automatic test_mode_toggle();
    drive(4'd5, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000);
    drive(4'd5, 1'b0, 1'b1, 1'b0, 4'h0, 12'h000);
    checks++;
    if (out_rgb !== 12'h555) begin
      failures++;
      $display("FAIL toggle_midframe: got %h exp 555", out_rgb);
    end
    drive(4'd5, 1'b1, 1'b1, 1'b0, 4'h0, 12'h000);
    drive(4'd5, 1'b1, 1'b1, 1'b0, 4'h0, 12'h000);
    checks++;
    if (out_rgb !== 12'hA3C) begin
      failures++;
      $display("FAIL toggle_nextframe: got %h exp a3c", out_rgb);
    end
    drive(4'd5, 1'b1, 1'b0, 1'b0, 4'h0, 12'h000);
    checks++;
    if (out_rgb !== 12'h555 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL single_pixel_frame: rgb=%h st=%0d exp 555,0", out_rgb, dbg_state);
    end
    drain("toggle");
  endtask

  task automatic test_same_cycle_write();
    drive(4'd2, 1'b0, 1'b1, 1'b1, 4'd2, 12'hF00);
    checks++;
    if (out_rgb !== 12'h222) begin
      failures++;
      $display("FAIL rbw_old: got %h exp 222", out_rgb);
    end
    drive(4'd2, 1'b1, 1'b1, 1'b0, 4'h0, 12'h000);
    checks++;
    if (out_rgb !== 12'hF00) begin
      failures++;
      $display("FAIL rbw_new: got %h exp f00", out_rgb);
    end
    drain("rbw");
  endtask

  task automatic test_frame_cnt();
    int          fd_base;
    logic [15:0] exp_cnt [4];
    exp_cnt[0] = 16'd1; exp_cnt[1] = 16'd2; exp_cnt[2] = 16'd3; exp_cnt[3] = 16'd0;
    fd_base = fd_count;
    for (int i = 0; i < 4; i++) begin
      drive(4'(i + 8), i == 3, 1'b0, 1'b0, 4'h0, 12'h000);
      @(posedge clk); #1;
      checks++;
      if (pix_cnt !== exp_cnt[i] || frame_done !== (i == 3)) begin
        failures++;
        $display("FAIL frame_cnt%0d: cnt=%0d fd=%b exp %0d,%b", i, pix_cnt, frame_done, exp_cnt[i], i == 3);
      end
    end
    drain("cnt");
    checks++;
    if (fd_count - fd_base != 1) begin
      failures++;
      $display("FAIL frame_done_pulses: got %0d exp 1", fd_count - fd_base);
    end
  endtask

  task automatic test_reset_midframe();
    pal_write(4'd7, 12'h0F0);
    drive(4'd7, 1'b0, 1'b1, 1'b0, 4'h0, 12'h000);
    drive(4'd1, 1'b0, 1'b1, 1'b0, 4'h0, 12'h000);
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_rgb !== 12'h000 || pix_cnt !== 16'd0 || frame_done !== 1'b0 ||
        in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL midreset_clear: vld=%b rgb=%h cnt=%0d fd=%b rdy=%b st=%0d exp 0,000,0,0,1,0",
               out_valid, out_rgb, pix_cnt, frame_done, in_ready, dbg_state);
    end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(4'd7, 1'b1, 1'b1, 1'b0, 4'h0, 12'h000);
    checks++;
    if (out_rgb !== 12'h777) begin
      failures++;
      $display("FAIL midreset_ramp: got %h exp 777", out_rgb);
    end
    drain("midreset");
  endtask

  task automatic test_back_to_back();
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 12'($urandom_range(0, 4095)));
    end
    drive(4'd0, 1'b1, 1'b0, 1'b0, 4'h0, 12'h000);
    rand_ready = 1'b0;
    drain("random");
  endtask

  initial begin
    model_reset();
    fd_count = 0;
    test_reset();
    test_replicate();
    test_palette();
    test_stall();
    test_mode_toggle();
    test_same_cycle_write();
    test_frame_cnt();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray2rgb_stream.md
GRAY2RGB_STREAM -- requirements
Module: gray2rgb_stream

Interface
REQ-001 SHALL have parameter PIX_CNT_W, default 16, setting the width of the per-frame pixel counter.
REQ-002 SHALL have ports clk, input, 1, the single clock; all logic is on the rising edge.
REQ-003 SHALL have ports rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports mode, input, 1: 0 = replicate, 1 = palette lookup.
REQ-005 SHALL have ports pal_we, input, 1, palette write strobe.
REQ-006 SHALL have ports pal_addr, input, 4, palette entry index.
REQ-007 SHALL have ports pal_wdata, input, 12, palette entry value {R[3:0],G[3:0],B[3:0]}.
REQ-008 SHALL have ports in_valid, input, 1, input pixel valid.
REQ-009 SHALL have ports in_ready, output, 1, input pixel accepted when in_valid && in_ready.
REQ-010 SHALL have ports in_gray, input, 4, gray pixel value.
REQ-011 SHALL have ports in_last, input, 1, marks the final pixel of a frame.
REQ-012 SHALL have ports out_valid, output, 1, output pixel valid.
REQ-013 SHALL have ports out_ready, input, 1, downstream accept.
REQ-014 SHALL have ports out_rgb, output, 12, RGB444 pixel {R,G,B}.
REQ-015 SHALL have ports out_last, output, 1, in_last delayed with its pixel.
REQ-016 SHALL have ports frame_done, output, 1, one-cycle pulse per completed frame.
REQ-017 SHALL have ports pix_cnt, output, PIX_CNT_W, output handshakes counted in the current frame.

Function
REQ-018 SHALL convert each accepted gray pixel g to RGB444: replicate mode -> {g,g,g}; palette mode -> palette[g].
REQ-019 SHALL present a pixel accepted in cycle N on out_valid/out_rgb/out_last in cycle N+1, with a single output register stage.
REQ-020 SHALL drive in_ready = !out_valid || out_ready, giving one pixel per cycle with no bubbles under continuous ready.
REQ-021 SHALL hold out_rgb, out_last and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL implement FSM IDLE/ACTIVE: IDLE->ACTIVE on input handshake with in_last=0; ACTIVE->IDLE on input handshake with in_last=1; a single-pixel frame (handshake with in_last=1 in IDLE) stays IDLE.
REQ-023 SHALL latch mode only on input handshakes taken in IDLE, and use the latched mode for all pixels of that frame; mode changes mid-frame are ignored.
REQ-024 SHALL write palette[pal_addr] <= pal_wdata on any cycle with pal_we, independent of the handshake.
REQ-025 SHALL give a pixel accepted in the same cycle as a write to its entry the OLD entry value (read-before-write).
REQ-026 SHALL increment pix_cnt on each output handshake, wrapping from all-ones to 0.
REQ-027 SHALL clear pix_cnt to 0 on the output handshake carrying out_last, instead of incrementing.
REQ-028 SHALL assert frame_done for exactly the cycle after the output handshake with out_last=1.

Reset
REQ-029 SHALL on rst_n=0 force out_valid=0, out_last=0, out_rgb=0, frame_done=0, pix_cnt=0, FSM=IDLE and latched mode=0.
REQ-030 SHALL on rst_n=0 reload palette[i] = {i,i,i} for i=0..15.
REQ-031 SHALL drop any pixel in flight when reset is asserted mid-frame, without emitting a frame_done.
REQ-032 SHALL drive in_ready=1 during reset and on the first cycle after reset.

Structure
REQ-033 SHALL take gray4_t (4 bits), rgb444_t (12 bits), the mode enum (MODE_REPL=0, MODE_PAL=1) and PAL_DEPTH=16 from the shared coproc package.
REQ-034 SHALL place the palette in sub-module gray_palette_rf: 16x12 register file, one write port, one async read port, async reset to the ramp.

Verification
REQ-035 SHALL cover: mode=0, gray 0..15 streamed with out_ready=1 -> out_rgb 0x000,0x111,...,0xFFF, one per cycle, latency 1.
REQ-036 SHALL cover: write palette[5]=0xA3C, frame in mode=1 with gray 5 -> out_rgb=0xA3C; gray 6 -> 0x666.
REQ-037 SHALL cover: out_ready low 3 cycles mid-stream -> in_ready low, out_rgb held, no pixel lost or duplicated.
REQ-038 SHALL cover: mode toggled 0->1 mid-frame -> frame stays replicate; next frame uses palette.
REQ-039 SHALL cover: same-cycle write palette[2]=0xF00 and accept gray 2 -> out 0x222; next gray 2 -> 0xF00.
REQ-040 SHALL cover: 4-pixel frame -> pix_cnt 1,2,3 then 0, and frame_done single pulse; rst_n pulse mid-frame -> outputs cleared, palette ramp restored.
